// File: rtl/resource_pool_manager.sv
// resource_pool_manager
//   Holds NUM_RES independent WIDTH-bit resource pools. One consume/refill
//   request is accepted at a time over a valid/ready handshake. Each request
//   gets exactly one granted/denied response. Consumes are all-or-nothing.
//   Refills saturate at full scale. An optional periodic regeneration tick
//   adds REGEN_AMT to every pool, saturating.
//
// Ports
//   clk, reset           clock (posedge), synchronous active-high reset
//   req_valid/req_ready  request handshake; ready only while idle
//   req_sel              pool index (out-of-range index is denied)
//   req_op               0 = consume, 1 = refill
//   req_amt              amount
//   rsp_valid/rsp_ready  response handshake; rsp_* held until taken
//   rsp_ok               1 = granted/applied, 0 = denied
//   rsp_level            selected pool after the op (0 for a bad index)
//   regen_en             regeneration counter advances only while high
//   levels               all pools, pool i at [i*WIDTH +: WIDTH]
//   empty                empty[i] = (pool i == 0)
module resource_pool_manager #(
    parameter int               NUM_RES      = 3,
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] INIT_LEVEL   = {WIDTH{1'b1}},
    parameter int               REGEN_PERIOD = 16,
    parameter logic [WIDTH-1:0] REGEN_AMT    = WIDTH'(1),
    parameter int               SEL_W        = (NUM_RES > 1) ? $clog2(NUM_RES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [SEL_W-1:0]         req_sel,
    input  logic                     req_op,
    input  logic [WIDTH-1:0]         req_amt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_ok,
    output logic [WIDTH-1:0]         rsp_level,
    input  logic                     regen_en,
    output logic [NUM_RES*WIDTH-1:0] levels,
    output logic [NUM_RES-1:0]       empty
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int   CNT_W    = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
    localparam int   CNT_LAST = (REGEN_PERIOD > 0) ? REGEN_PERIOD - 1 : 0;
    localparam logic REGEN_ON = (REGEN_PERIOD > 0);

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] amt_q, amt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_ok_q, rsp_ok_d;
    logic [WIDTH-1:0] rsp_level_q, rsp_level_d;
    logic [WIDTH-1:0] pool_q [NUM_RES];
    logic [WIDTH-1:0] pool_d [NUM_RES];
    logic             tick;

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
    endfunction

    // Regeneration counter: wraps on the tick edge, frozen while regen_en is low.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (REGEN_ON && regen_en) begin
            if (cnt_q == CNT_W'(CNT_LAST)) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Control FSM, request capture and pool update.
    // On a collision the op is evaluated against the pre-tick level and its
    // result is reported; the regen increment is then layered on top.
    always_comb begin
        logic [WIDTH-1:0] lvl;
        state_d     = state_q;
        sel_d       = sel_q;
        op_d        = op_q;
        amt_d       = amt_q;
        rsp_ok_d    = rsp_ok_q;
        rsp_level_d = rsp_level_q;
        lvl         = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = EXEC;
                    sel_d   = req_sel;
                    op_d    = req_op;
                    amt_d   = req_amt;
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_ok_d    = 1'b0;
                rsp_level_d = '0;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned i = 0; i < NUM_RES; i++) begin
            lvl = pool_q[i];
            if (state_q == EXEC && sel_q == SEL_W'(i)) begin
                if (op_q) begin
                    lvl      = sat_add(lvl, amt_q);
                    rsp_ok_d = 1'b1;
                end else if (lvl >= amt_q) begin
                    lvl      = lvl - amt_q;
                    rsp_ok_d = 1'b1;
                end
                rsp_level_d = lvl;
            end
            if (tick) begin
                lvl = sat_add(lvl, REGEN_AMT);
            end
            pool_d[i] = lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            op_q        <= 1'b0;
            amt_q       <= '0;
            cnt_q       <= '0;
            rsp_ok_q    <= 1'b0;
            rsp_level_q <= '0;
            for (int unsigned i = 0; i < NUM_RES; i++) begin
                pool_q[i] <= INIT_LEVEL;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            cnt_q       <= cnt_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_level_q <= rsp_level_d;
            for (int unsigned i = 0; i < NUM_RES; i++) begin
                pool_q[i] <= pool_d[i];
            end
        end
    end

    always_comb begin
        levels = '0;
        empty  = '0;
        for (int unsigned i = 0; i < NUM_RES; i++) begin
            levels[i*WIDTH +: WIDTH] = pool_q[i];
            empty[i]                 = (pool_q[i] == '0);
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_ok    = rsp_ok_q;
    assign rsp_level = rsp_level_q;

endmodule

// File: tb/tb_resource_pool_manager.sv
// tb_resource_pool_manager
//   Table-driven directed vectors, hand-written multi-cycle corner cases and
//   randomized transactions checked against a pool-level reference model.
`timescale 1ns/1ps
module tb_resource_pool_manager;

    localparam int PERIOD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_sel;
    logic        req_op;
    logic [7:0]  req_amt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_ok;
    logic [7:0]  rsp_level;
    logic        regen_en;
    logic [23:0] levels;
    logic [2:0]  empty;

    resource_pool_manager #(
        .NUM_RES(3),
        .WIDTH(8),
        .INIT_LEVEL(8'hFF),
        .REGEN_PERIOD(PERIOD),
        .REGEN_AMT(8'd1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_sel(req_sel),
        .req_op(req_op),
        .req_amt(req_amt),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_ok(rsp_ok),
        .rsp_level(rsp_level),
        .regen_en(regen_en),
        .levels(levels),
        .empty(empty)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: plain integers per pool.
    int m_pool [3];
    int m_cnt;
    int m_sel, m_op, m_amt;
    bit m_ok;
    int m_lvl;
    bit rand_regen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model_levels();
        return {8'(m_pool[2]), 8'(m_pool[1]), 8'(m_pool[0])};
    endfunction

    function automatic logic [2:0] model_empty();
        return {m_pool[2] == 0, m_pool[1] == 0, m_pool[0] == 0};
    endfunction

    task automatic model_exec();
        if (m_sel >= 3) begin
            m_ok  = 1'b0;
            m_lvl = 0;
        end else if (m_op != 0) begin
            m_pool[m_sel] = (m_pool[m_sel] + m_amt > 255) ? 255 : m_pool[m_sel] + m_amt;
            m_ok  = 1'b1;
            m_lvl = m_pool[m_sel];
        end else begin
            m_ok = (m_pool[m_sel] >= m_amt);
            if (m_ok) m_pool[m_sel] = m_pool[m_sel] - m_amt;
            m_lvl = m_pool[m_sel];
        end
    endtask

    // One clock: the model sees the same inputs the DUT sees at the edge.
    task automatic cyc(input bit exec);
        if (rand_regen) regen_en = 1'($urandom_range(0, 1));
        @(posedge clk);
        if (reset) begin
            foreach (m_pool[i]) m_pool[i] = 255;
            m_cnt = 0;
        end else begin
            if (exec) model_exec();
            if (regen_en) begin
                if (m_cnt == PERIOD - 1) begin
                    m_cnt = 0;
                    foreach (m_pool[i]) m_pool[i] = (m_pool[i] >= 255) ? 255 : m_pool[i] + 1;
                end else begin
                    m_cnt++;
                end
            end
        end
        #1;
    endtask

    task automatic txn(input int sel, input int op, input int amt, input int hold,
                       output logic ok_o, output logic [7:0] lvl_o);
        int w;
        ok_o  = 1'bx;
        lvl_o = 'x;
        req_sel = 2'(sel); req_op = op[0]; req_amt = 8'(amt); req_valid = 1'b1;
        m_sel = sel; m_op = op; m_amt = amt;
        w = 0;
        while (!req_ready && w < 10) begin
            cyc(1'b0);
            w++;
        end
        if (!req_ready) begin
            n_chk++; n_fail++;
            $display("FAIL txn_accept_timeout: req_ready got 0 expected 1");
            req_valid = 1'b0;
            return;
        end
        cyc(1'b0);
        req_valid = 1'b0;
        cyc(1'b1);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_ok", rsp_ok, m_ok);
        chk("rsp_level", rsp_level, m_lvl);
        ok_o  = rsp_ok;
        lvl_o = rsp_level;
        repeat (hold) begin
            cyc(1'b0);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_level", rsp_level, m_lvl);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        cyc(1'b0);
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
        chk("levels", levels, model_levels());
        chk("empty", empty, model_empty());
    endtask

    typedef struct {
        int         sel;
        int         op;
        int         amt;
        logic       exp_ok;
        logic [7:0] exp_lvl;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        logic [7:0] lvl;

        vecs[0]  = '{1, 0, 8'h40, 1'b1, 8'hBF};
        vecs[1]  = '{1, 0, 8'hC0, 1'b0, 8'hBF};
        vecs[2]  = '{0, 0, 8'h0F, 1'b1, 8'hF0};
        vecs[3]  = '{0, 1, 8'h20, 1'b1, 8'hFF};
        vecs[4]  = '{3, 0, 8'h01, 1'b0, 8'h00};
        vecs[5]  = '{1, 0, 8'h00, 1'b1, 8'hBF};
        vecs[6]  = '{1, 1, 8'h30, 1'b1, 8'hEF};
        vecs[7]  = '{1, 0, 8'hEF, 1'b1, 8'h00};
        vecs[8]  = '{1, 0, 8'h01, 1'b0, 8'h00};
        vecs[9]  = '{1, 1, 8'hFF, 1'b1, 8'hFF};
        vecs[10] = '{3, 1, 8'h10, 1'b0, 8'h00};
        vecs[11] = '{2, 0, 8'hFF, 1'b1, 8'h00};

        reset = 1'b1; req_valid = 1'b0; req_sel = '0; req_op = 1'b0; req_amt = '0;
        rsp_ready = 1'b0; regen_en = 1'b0;
        m_sel = 0; m_op = 0; m_amt = 0; m_ok = 1'b0; m_lvl = 0;
        cyc(1'b0);
        cyc(1'b0);
        reset = 1'b0;
        chk("reset_levels", levels, 24'hFFFFFF);
        chk("reset_empty", empty, 3'b000);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_ok", rsp_ok, 0);
        chk("reset_rsp_level", rsp_level, 0);

        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].sel, vecs[i].op, vecs[i].amt, 0, ok, lvl);
            chk($sformatf("vec%0d_ok", i), ok, vecs[i].exp_ok);
            chk($sformatf("vec%0d_level", i), lvl, vecs[i].exp_lvl);
        end
        chk("table_levels", levels, 24'h00FFFF);
        chk("table_empty2", empty, 3'b100);

        // Regeneration: two ticks in eight enabled cycles, then frozen.
        regen_en = 1'b1;
        repeat (8) cyc(1'b0);
        regen_en = 1'b0;
        chk("regen_levels", levels, 24'h02FFFF);
        chk("regen_empty", empty, 3'b000);
        repeat (10) cyc(1'b0);
        chk("regen_hold_levels", levels, 24'h02FFFF);

        // Backpressure with a second request already waiting.
        req_valid = 1'b1; req_sel = 2'd0; req_op = 1'b0; req_amt = 8'h10;
        m_sel = 0; m_op = 0; m_amt = 8'h10;
        cyc(1'b0);
        req_op = 1'b1; req_amt = 8'h05;
        chk("bp_exec_ready", req_ready, 0);
        cyc(1'b1);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_level", rsp_level, 8'hEF);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            chk($sformatf("bp_hold%0d_valid", i), rsp_valid, 1);
            chk($sformatf("bp_hold%0d_ready", i), req_ready, 0);
            chk($sformatf("bp_hold%0d_ok", i), rsp_ok, 1);
            chk($sformatf("bp_hold%0d_level", i), rsp_level, 8'hEF);
        end
        rsp_ready = 1'b1;
        cyc(1'b0);
        rsp_ready = 1'b0;
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_ready", req_ready, 1);
        m_op = 1; m_amt = 8'h05;
        cyc(1'b0);
        req_valid = 1'b0;
        chk("bp_second_accept", req_ready, 0);
        cyc(1'b1);
        chk("bp_second_valid", rsp_valid, 1);
        chk("bp_second_level", rsp_level, 8'hF4);
        rsp_ready = 1'b1;
        cyc(1'b0);
        rsp_ready = 1'b0;
        chk("bp_levels", levels, 24'h02FFF4);
        chk("bp_model", levels, model_levels());

        // Reset while the request sits in EXEC.
        req_valid = 1'b1; req_sel = 2'd1; req_op = 1'b0; req_amt = 8'h50;
        cyc(1'b0);
        req_valid = 1'b0;
        chk("rst_exec_busy", req_ready, 0);
        reset = 1'b1;
        cyc(1'b0);
        reset = 1'b0;
        chk("rst_exec_levels", levels, 24'hFFFFFF);
        chk("rst_exec_ready", req_ready, 1);
        repeat (3) begin
            cyc(1'b0);
            chk("rst_exec_no_rsp", rsp_valid, 0);
        end

        // Consume landing on the regen tick edge.
        regen_en = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        req_valid = 1'b1; req_sel = 2'd0; req_op = 1'b0; req_amt = 8'h10;
        m_sel = 0; m_op = 0; m_amt = 8'h10;
        cyc(1'b0);
        req_valid = 1'b0;
        cyc(1'b1);
        regen_en = 1'b0;
        chk("coll_ok", rsp_ok, 1);
        chk("coll_rsp_level", rsp_level, 8'hEF);
        chk("coll_levels", levels, 24'hFFFFF0);
        chk("coll_model", levels, model_levels());
        rsp_ready = 1'b1;
        cyc(1'b0);
        rsp_ready = 1'b0;

        // Randomized traffic with random regen_en and response delays.
        rand_regen = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int sel, op, amt;
            sel = $urandom_range(0, 3);
            op  = $urandom_range(0, 1);
            amt = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 8'h30) : $urandom_range(0, 255);
            txn(sel, op, amt, $urandom_range(0, 3), ok, lvl);
        end
        rand_regen = 1'b0;
        regen_en = 1'b0;
        chk("final_levels", levels, model_levels());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
